// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues synchronous imem reads and loads IF/ID.
// A one-entry hold buffer keeps the in-flight response when decode stalls.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             id_stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] resp_pc;
    logic        resp_valid;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        hold_valid;

    logic        issue;
    logic        load_valid;
    logic [31:0] load_instr;
    logic [31:0] load_pc;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsb;

    assign imem_addr           = pc_q;
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // The hold buffer is always older than the live response, so it wins.
    always_comb begin
        issue      = !id_stall && !redirect_valid;
        load_valid = hold_valid || resp_valid;
        load_instr = imem_rdata;
        load_pc    = resp_pc;
        if (hold_valid) begin
            load_instr = hold_instr;
            load_pc    = hold_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            resp_pc        <= 32'h0;
            resp_valid     <= 1'b0;
            hold_instr     <= 32'h0;
            hold_pc        <= 32'h0;
            hold_valid     <= 1'b0;
            if_id_instr    <= 32'h0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
            fetch_count    <= '0;
        end else if (redirect_valid) begin
            pc_q        <= redirect_target;
            resp_valid  <= 1'b0;
            hold_valid  <= 1'b0;
            if_id_valid <= 1'b0;
        end else if (issue) begin
            resp_valid  <= 1'b1;
            resp_pc     <= pc_q;
            pc_q        <= pc_q + 32'd4;
            hold_valid  <= 1'b0;
            if_id_valid <= load_valid;
            if (load_valid) begin
                if_id_instr    <= load_instr;
                if_id_pc       <= load_pc;
                if_id_pc_plus4 <= load_pc + 32'd4;
                fetch_count    <= fetch_count + CNT_W'(1);
            end
        end else begin
            // Stalled: no new read, park the response that is already in flight.
            resp_valid <= 1'b0;
            if (resp_valid && !hold_valid) begin
                hold_instr <= imem_rdata;
                hold_pc    <= resp_pc;
                hold_valid <= 1'b1;
            end
        end
    end

    // Only one read can be outstanding when a stall begins.
    a_no_hold_overflow: assert property (@(posedge clk) disable iff (reset)
        !(id_stall && !redirect_valid && resp_valid && hold_valid));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table plus randomized
// stall/redirect/reset traffic checked against a program-order fetch model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= mem[imem_addr[9:2]];

    instruction_fetch_unit #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic        chkf;
        logic [31:0] ei;
        logic [31:0] ep;
        logic [31:0] ep4;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stall, logic rv, logic [31:0] rpc,
                                logic ev, logic chkf, logic [31:0] ei, logic [31:0] ep,
                                logic [31:0] ep4, logic [31:0] ecnt);
        vec_t v;
        v.rst = rst; v.stall = stall; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.chkf = chkf; v.ei = ei; v.ep = ep; v.ep4 = ep4; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic drive_edge(input logic r, input logic s, input logic v, input logic [31:0] p);
        reset          = r;
        id_stall       = s;
        redirect_valid = v;
        redirect_pc    = p;
        @(posedge clk);
        #1;
    endtask

    // Model state for the random phase
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_count, m_next;
    logic        m_issued;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]   = 32'h2401_0005;
        mem[1]   = 32'h2422_000A;
        mem[2]   = 32'h0022_1820;
        mem[3]   = 32'h1234_5678;
        mem[16]  = 32'hAC03_0000;
        mem[255] = 32'hDEAD_BEEF;

        // Reset, free run
        vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h0,        32'h0,        32'h0,32'd0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h24010005,32'h0,        32'h4,32'd1));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h2422000A,32'h4,        32'h8,32'd2));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h00221820,32'h8,        32'hC,32'd3));
        // Reset, stall 3 cycles with pc 4 in IF/ID
        vecs.push_back(mk(1,0,0,32'h0,        0,1,32'h0,        32'h0,        32'h0,32'd0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h24010005,32'h0,        32'h4,32'd1));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h2422000A,32'h4,        32'h8,32'd2));
        vecs.push_back(mk(0,1,0,32'h0,        1,1,32'h2422000A,32'h4,        32'h8,32'd2));
        vecs.push_back(mk(0,1,0,32'h0,        1,1,32'h2422000A,32'h4,        32'h8,32'd2));
        vecs.push_back(mk(0,1,0,32'h0,        1,1,32'h2422000A,32'h4,        32'h8,32'd2));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h00221820,32'h8,        32'hC,32'd3));
        // Redirect to 0x42 while pc 8 is in IF/ID
        vecs.push_back(mk(0,0,1,32'h42,       0,0,32'h0,        32'h0,        32'h0,32'd3));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd3));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hAC030000,32'h40,       32'h44,32'd4));
        // Stall (hold fills), then redirect together with stall
        vecs.push_back(mk(0,1,0,32'h0,        1,1,32'hAC030000,32'h40,       32'h44,32'd4));
        vecs.push_back(mk(0,1,1,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd4));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd4));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h24010005,32'h0,        32'h4,32'd5));
        // Redirect to top of address space, low bits ignored
        vecs.push_back(mk(0,0,1,32'hFFFFFFFE, 0,0,32'h0,        32'h0,        32'h0,32'd5));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd5));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'hDEADBEEF,32'hFFFFFFFC, 32'h0,32'd6));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h24010005,32'h0,        32'h4,32'd7));
        // Reset mid-stream with hold buffer occupied
        vecs.push_back(mk(0,1,0,32'h0,        1,1,32'h24010005,32'h0,        32'h4,32'd7));
        vecs.push_back(mk(1,1,0,32'h0,        0,1,32'h0,        32'h0,        32'h0,32'd0));
        vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        32'h0,        32'h0,32'd0));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h24010005,32'h0,        32'h4,32'd1));
        vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h2422000A,32'h4,        32'h8,32'd2));

        for (int i = 0; i < vecs.size(); i++) begin
            drive_edge(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc);
            chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].ev});
            chk($sformatf("v%0d_count", i), fetch_count, vecs[i].ecnt);
            if (vecs[i].chkf) begin
                chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].ei);
                chk($sformatf("v%0d_pc", i), if_id_pc, vecs[i].ep);
                chk($sformatf("v%0d_pc4", i), if_id_pc_plus4, vecs[i].ep4);
            end
            if (vecs[i].rst)
                chk($sformatf("v%0d_addr", i), imem_addr, 32'h0);
            else if (vecs[i].rv)
                chk($sformatf("v%0d_addr", i), imem_addr, {vecs[i].rpc[31:2], 2'b00});
        end

        // Random phase against a program-order model
        drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
        m_valid = 1'b0; m_count = 32'h0; m_next = 32'h0; m_issued = 1'b0;
        m_instr = 32'h0; m_pc = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            logic        r, s, v;
            logic [31:0] p;
            r = ($urandom_range(0, 99) < 2);
            v = !r && ($urandom_range(0, 99) < 10);
            s = ($urandom_range(0, 99) < 35);
            if ($urandom_range(0, 3) == 0) p = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else                           p = 32'($urandom_range(0, 1023));
            drive_edge(r, s, v, p);
            if (r) begin
                m_valid = 1'b0; m_count = 32'h0; m_next = 32'h0; m_issued = 1'b0;
                chk("r_rst_valid", {31'h0, if_id_valid}, 32'h0);
                chk("r_rst_instr", if_id_instr, 32'h0);
                chk("r_rst_pc", if_id_pc, 32'h0);
                chk("r_rst_pc4", if_id_pc_plus4, 32'h0);
                chk("r_rst_addr", imem_addr, 32'h0);
            end else if (v) begin
                m_valid = 1'b0; m_next = {p[31:2], 2'b00}; m_issued = 1'b0;
                chk("r_redir_valid", {31'h0, if_id_valid}, 32'h0);
                chk("r_redir_addr", imem_addr, m_next);
            end else if (s) begin
                chk("r_stall_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
                if (m_valid) begin
                    chk("r_stall_instr", if_id_instr, m_instr);
                    chk("r_stall_pc", if_id_pc, m_pc);
                end
            end else begin
                m_valid = m_issued;
                if (m_issued) begin
                    m_instr = mem[m_next[9:2]];
                    m_pc    = m_next;
                    m_next  = m_next + 32'd4;
                    m_count = m_count + 32'd1;
                end
                m_issued = 1'b1;
                chk("r_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
                if (m_valid) begin
                    chk("r_instr", if_id_instr, m_instr);
                    chk("r_pc", if_id_pc, m_pc);
                    chk("r_pc4", if_id_pc_plus4, m_pc + 32'd4);
                end
            end
            chk("r_count", fetch_count, m_count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the synchronous instruction-memory read interface: owns the PC, drives the read address, consumes `imem_rdata` one cycle later, and loads the IF/ID pipeline register.
- Absorbs the one-cycle read latency across downstream stalls using a one-entry skid buffer.
- Applies branch/jump redirects with flush.
- Sits between `instruction_memory` and the decode stage of the MIPS pipeline.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- imem_addr  out  32  read address to instruction memory; equals pc_q (registered).
- imem_rdata  in  32  memory data; returns mem[addr presented in previous cycle].
- id_stall  in  1  decode stall; IF/ID holds while high.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and treated as 00.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc  out  32  PC of if_id_instr.
- if_id_pc_plus4  out  32  if_id_pc + 4, modulo 2^32.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- fetch_count  out  CNT_W  number of valid instructions loaded into IF/ID since reset.

Behaviour:
- Reset values (while reset high at a rising edge):
  - pc_q = RESET_PC.
  - resp_valid = 0, hold_valid = 0, if_id_valid = 0.
  - if_id_instr = 0, if_id_pc = 0, if_id_pc_plus4 = 0, fetch_count = 0.
  - Reset overrides every other input.
- Issue rule: issue = !id_stall && !redirect_valid.
  - If issue: resp_valid <= 1, resp_pc <= pc_q, pc_q <= pc_q + 4 (wraps from FFFFFFFC to 00000000).
  - Otherwise pc_q holds and resp_valid <= 0.
- Response: when resp_valid = 1, imem_rdata is the instruction at resp_pc this cycle. Reads performed while not issuing are ignored.
- IF/ID load when !id_stall and not redirecting:
  - Source is the hold buffer if hold_valid, else the response if resp_valid.
  - if_id_valid <= 1 if either source is valid, else 0 (bubble); hold_valid <= 0.
  - A buffered instruction always precedes the live response, so program order is preserved.
- Stall (id_stall = 1, no redirect):
  - IF/ID holds all fields.
  - If resp_valid and !hold_valid: hold_instr <= imem_rdata, hold_pc <= resp_pc, hold_valid <= 1.
  - At most one response can be in flight at stall onset, so the hold buffer never overflows.
  - A second response during a stall is impossible by construction; assert in simulation.
- Redirect (redirect_valid = 1, highest priority after reset, independent of id_stall):
  - pc_q <= {redirect_pc[31:2], 2'b00}.
  - resp_valid <= 0, hold_valid <= 0, if_id_valid <= 0. Instruction fields may keep stale values.
- Latencies:
  - Reset deassert to first if_id_valid = 1 with pc RESET_PC: 2 rising edges.
  - Redirect cycle to first valid target instruction in IF/ID: 3 rising edges, with no stall.
- Steady state with no stalls: one instruction per cycle, consecutive PCs +4.
- fetch_count increments by 1 on every edge where IF/ID loads with valid = 1; wraps at 2^CNT_W.
- Simultaneous id_stall and redirect_valid: redirect wins; the flush occurs.

Test Plan:
- Memory preloaded: mem[0]=24010005, mem[4]=2422000A, mem[8]=00221820, mem[40]=AC030000.
- Reset then free-run: first valid IF/ID is instr 24010005, pc 0, pc_plus4 4, two edges after reset release. Then 2422000A / pc 4, then 00221820 / pc 8 on successive cycles; fetch_count = 3.
- Stall for 3 cycles while pc 4 is in IF/ID: IF/ID stays 2422000A / 4, hold buffer captures 00221820. After release, IF/ID shows 00221820 / 8 on the next edge, with no duplicate or skipped instruction.
- Redirect to 32'h00000042 while pc 8 is in IF/ID: if_id_valid = 0 for two cycles, then AC030000 / pc 40; in-flight pc 0C is discarded and fetch_count excludes it.
- Redirect asserted together with id_stall: flush still happens, if_id_valid = 0 next edge, hold buffer cleared.
- Redirect to FFFFFFFC: next fetched pcs are FFFFFFFC then 00000000; if_id_pc_plus4 of FFFFFFFC reads 00000000.
- Reset asserted mid-stream with hold_valid = 1: all outputs return to reset values next edge; restart fetches from RESET_PC with 2-edge latency.
